// File: rtl/tank_game_ctrl.sv
// Game-tick sequencer feeding the storage block: latches player requests between ticks,
// then steps tank/projectile slots through load/commit/gap so storage updates each position.
module tank_game_ctrl #(
    parameter int TICK_DIV   = 12500000,
    parameter int CNT_W      = 24,
    parameter int PROJ_RANGE = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] p1_move,
    input  logic       p1_fire,
    input  logic [3:0] p2_move,
    input  logic       p2_fire,
    output logic [3:0] mode,
    output logic       wren,
    output logic       load_out,
    output logic [7:0] data,
    output logic       p1_proj_active,
    output logic       p2_proj_active,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T1_LOAD, S_T1_COMMIT, S_T1_GAP,
        S_P1_LOAD, S_P1_COMMIT, S_P1_GAP,
        S_T2_LOAD, S_T2_COMMIT, S_T2_GAP,
        S_P2_LOAD, S_P2_COMMIT, S_P2_GAP,
        S_DONE
    } state_t;

    localparam logic [7:0] DIR_UP    = 8'h00;
    localparam logic [7:0] DIR_DOWN  = 8'h01;
    localparam logic [7:0] DIR_LEFT  = 8'h03;
    localparam logic [7:0] DIR_RIGHT = 8'h07;

    // Move bits are {right,left,down,up}; up has highest priority.
    function automatic logic [7:0] dir_code(input logic [3:0] mv);
        if (mv[0])      return DIR_UP;
        else if (mv[1]) return DIR_DOWN;
        else if (mv[2]) return DIR_LEFT;
        else            return DIR_RIGHT;
    endfunction

    // First LOAD state of an active slot at or after index 'from'; DONE if none.
    function automatic state_t first_slot(input logic [3:0] go, input int from);
        state_t s;
        s = S_DONE;
        for (int i = 3; i >= 0; i--)
            if (i >= from && go[i]) s = state_t'(4'(1 + 3 * i));
        return s;
    endfunction

    state_t state, next_state;
    logic [CNT_W-1:0] tick_cnt;
    logic tick, tick_acc;
    logic [3:0] p1_mv_l, p2_mv_l;
    logic p1_fire_l, p2_fire_l;
    logic t1_go, t2_go;
    logic [7:0] t1_face, t2_face, p1_dir, p2_dir;
    logic [7:0] t1_face_n, t2_face_n, data_hold;
    logic [3:0] p1_life, p2_life;
    logic p1_fire_ok, p2_fire_ok;
    logic [3:0] go_new, go_cur;

    assign tick     = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign tick_acc = tick && (state == S_IDLE);

    // Resolved snapshot values, used both to register and to pick the first slot.
    assign t1_face_n  = (|p1_mv_l) ? dir_code(p1_mv_l) : t1_face;
    assign t2_face_n  = (|p2_mv_l) ? dir_code(p2_mv_l) : t2_face;
    assign p1_fire_ok = p1_fire_l && !p1_proj_active;
    assign p2_fire_ok = p2_fire_l && !p2_proj_active;
    assign go_new = {p2_proj_active | p2_fire_ok, |p2_mv_l, p1_proj_active | p1_fire_ok, |p1_mv_l};
    assign go_cur = {p2_proj_active, t2_go, p1_proj_active, t1_go};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            tick_cnt       <= '0;
            p1_mv_l        <= '0;
            p2_mv_l        <= '0;
            p1_fire_l      <= 1'b0;
            p2_fire_l      <= 1'b0;
            t1_go          <= 1'b0;
            t2_go          <= 1'b0;
            t1_face        <= DIR_DOWN;
            t2_face        <= DIR_UP;
            p1_dir         <= DIR_UP;
            p2_dir         <= DIR_UP;
            p1_life        <= '0;
            p2_life        <= '0;
            p1_proj_active <= 1'b0;
            p2_proj_active <= 1'b0;
            data_hold      <= DIR_UP;
        end else begin
            state     <= next_state;
            data_hold <= data;
            tick_cnt  <= tick ? '0 : tick_cnt + CNT_W'(1);
            if (tick_acc) begin
                // Requests present in the tick cycle start the new window.
                p1_mv_l   <= p1_move;
                p2_mv_l   <= p2_move;
                p1_fire_l <= p1_fire;
                p2_fire_l <= p2_fire;
                t1_go     <= |p1_mv_l;
                t2_go     <= |p2_mv_l;
                t1_face   <= t1_face_n;
                t2_face   <= t2_face_n;
                if (p1_fire_ok) begin
                    p1_proj_active <= 1'b1;
                    p1_dir         <= t1_face_n;
                    p1_life        <= 4'(PROJ_RANGE);
                end
                if (p2_fire_ok) begin
                    p2_proj_active <= 1'b1;
                    p2_dir         <= t2_face_n;
                    p2_life        <= 4'(PROJ_RANGE);
                end
            end else begin
                p1_mv_l   <= p1_mv_l | p1_move;
                p2_mv_l   <= p2_mv_l | p2_move;
                p1_fire_l <= p1_fire_l | p1_fire;
                p2_fire_l <= p2_fire_l | p2_fire;
            end
            if (state == S_P1_COMMIT) begin
                p1_life <= p1_life - 4'd1;
                if (p1_life == 4'd1) p1_proj_active <= 1'b0;
            end
            if (state == S_P2_COMMIT) begin
                p2_life <= p2_life - 4'd1;
                if (p2_life == 4'd1) p2_proj_active <= 1'b0;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (tick_acc) next_state = first_slot(go_new, 0);
            S_T1_LOAD:   next_state = S_T1_COMMIT;
            S_T1_COMMIT: next_state = S_T1_GAP;
            S_T1_GAP:    next_state = first_slot(go_cur, 1);
            S_P1_LOAD:   next_state = S_P1_COMMIT;
            S_P1_COMMIT: next_state = S_P1_GAP;
            S_P1_GAP:    next_state = first_slot(go_cur, 2);
            S_T2_LOAD:   next_state = S_T2_COMMIT;
            S_T2_COMMIT: next_state = S_T2_GAP;
            S_T2_GAP:    next_state = first_slot(go_cur, 3);
            S_P2_LOAD:   next_state = S_P2_COMMIT;
            S_P2_COMMIT: next_state = S_P2_GAP;
            S_P2_GAP:    next_state = S_DONE;
            S_DONE:      next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mode       = 4'b0000;
        wren       = 1'b0;
        load_out   = 1'b0;
        data       = data_hold;
        busy       = (state != S_IDLE);
        frame_done = (state == S_DONE);
        case (state)
            S_T1_LOAD, S_T1_COMMIT: begin mode = 4'b0001; data = t1_face; end
            S_P1_LOAD, S_P1_COMMIT: begin mode = 4'b0011; data = p1_dir;  end
            S_T2_LOAD, S_T2_COMMIT: begin mode = 4'b0101; data = t2_face; end
            S_P2_LOAD, S_P2_COMMIT: begin mode = 4'b0111; data = p2_dir;  end
            default: ;
        endcase
        if (state inside {S_T1_LOAD, S_P1_LOAD, S_T2_LOAD, S_P2_LOAD}) begin
            wren     = 1'b1;
            load_out = 1'b1;
        end
    end

endmodule

// File: tb/tb_tank_game_ctrl.sv
// Directed bench for tank_game_ctrl with TICK_DIV=8 and PROJ_RANGE=3.
module tb_tank_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] p1_move, p2_move;
    logic       p1_fire, p2_fire;
    logic [3:0] mode;
    logic       wren, load_out;
    logic [7:0] data;
    logic       p1_proj_active, p2_proj_active, busy, frame_done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    tank_game_ctrl #(.TICK_DIV(8), .CNT_W(4), .PROJ_RANGE(3)) dut (
        .clk(clk), .reset(reset),
        .p1_move(p1_move), .p1_fire(p1_fire),
        .p2_move(p2_move), .p2_fire(p2_fire),
        .mode(mode), .wren(wren), .load_out(load_out), .data(data),
        .p1_proj_active(p1_proj_active), .p2_proj_active(p2_proj_active),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later; cyc counts edges since reset release.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic check_slot(input string tag, input logic [3:0] m, input logic [7:0] d);
        check({tag, "_ld_mode"}, 8'(mode), 8'(m));
        check({tag, "_ld_wren"}, 8'(wren), 8'h01);
        check({tag, "_ld_load"}, 8'(load_out), 8'h01);
        check({tag, "_ld_data"}, data, d);
        check({tag, "_ld_busy"}, 8'(busy), 8'h01);
        step();
        check({tag, "_cm_mode"}, 8'(mode), 8'(m));
        check({tag, "_cm_wren"}, 8'(wren), 8'h00);
        check({tag, "_cm_load"}, 8'(load_out), 8'h00);
        check({tag, "_cm_data"}, data, d);
        step();
        check({tag, "_gap_mode"}, 8'(mode), 8'h00);
        check({tag, "_gap_wren"}, 8'(wren), 8'h00);
        step();
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done_pulse"}, 8'(frame_done), 8'h01);
        check({tag, "_done_mode"}, 8'(mode), 8'h00);
        step();
        check({tag, "_after_done"}, 8'(frame_done), 8'h00);
        check({tag, "_after_busy"}, 8'(busy), 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        p1_move = '0; p2_move = '0; p1_fire = 1'b0; p2_fire = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_mode", 8'(mode), 8'h00);
        check("rst_wren", 8'(wren), 8'h00);
        check("rst_load", 8'(load_out), 8'h00);
        check("rst_data", data, 8'h00);
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_done", 8'(frame_done), 8'h00);
        check("rst_p1a", 8'(p1_proj_active), 8'h00);
        check("rst_p2a", 8'(p2_proj_active), 8'h00);
        reset = 1'b0;
        cyc = 0;

        // Single tank 1 move down; tick cycle is cyc 7, sequence starts at 8.
        p1_move = 4'b0010; step(); p1_move = '0;
        goto(7);
        check("a_pre_busy", 8'(busy), 8'h00);
        check("a_pre_mode", 8'(mode), 8'h00);
        step();
        check_slot("a_t1", 4'b0001, 8'h01);
        check_done("a");                          // frame_done at cyc 11: 5 cycles from tick

        // Tank 2 fires facing up; projectile lives three ticks.
        p2_fire = 1'b1; step(); p2_fire = 1'b0;   // cyc 13
        goto(16);
        check_slot("b1_p2", 4'b0111, 8'h00);
        check_done("b1");
        check("b1_p2a", 8'(p2_proj_active), 8'h01);
        p2_fire = 1'b1; step(); p2_fire = 1'b0;   // second fire during flight, ignored
        goto(24);
        check_slot("b2_p2", 4'b0111, 8'h00);
        check_done("b2");
        check("b2_p2a", 8'(p2_proj_active), 8'h01);
        goto(32);
        check_slot("b3_p2", 4'b0111, 8'h00);
        check("b3_p2a_off", 8'(p2_proj_active), 8'h00);
        check_done("b3");
        goto(40);                                 // no active slots: straight to DONE
        check("b4_done", 8'(frame_done), 8'h01);
        check("b4_wren", 8'(wren), 8'h00);
        check("b4_mode", 8'(mode), 8'h00);
        step();
        check("b4_after", 8'(frame_done), 8'h00);

        // Multi-bit moves resolve by priority; tank 1 before tank 2.
        p1_move = 4'b1111; p2_move = 4'b1100; step(); p1_move = '0; p2_move = '0;
        goto(48);
        check_slot("c_t1", 4'b0001, 8'h00);
        check_slot("c_t2", 4'b0101, 8'h03);
        check_done("c");                          // ends at cyc 55

        // Move right and fire together: projectile takes the new facing.
        step();                                   // cyc 56
        p1_move = 4'b1000; p1_fire = 1'b1; step(); p1_move = '0; p1_fire = 1'b0;
        goto(64);
        check_slot("d_t1", 4'b0001, 8'h07);
        check_slot("d_p1", 4'b0011, 8'h07);
        check("d_p1a", 8'(p1_proj_active), 8'h01);
        check_done("d");                          // now at cyc 71, the tick cycle

        // Request held only during the tick cycle lands in the following sequence.
        p2_move = 4'b0001; step(); p2_move = '0;  // cyc 72
        check_slot("e1_p1", 4'b0011, 8'h07);
        check_done("e1");                         // tank 2 absent from this sequence
        goto(80);
        check_slot("e2_p1", 4'b0011, 8'h07);
        check("e2_p1a_off", 8'(p1_proj_active), 8'h00);
        check("e2_t2_ld_mode", 8'(mode), 8'h05);
        check("e2_t2_ld_wren", 8'(wren), 8'h01);
        check("e2_t2_ld_data", data, 8'h00);
        step();
        check("e2_t2_cm_mode", 8'(mode), 8'h05);
        check("e2_t2_cm_wren", 8'(wren), 8'h00);
        check("e2_t2_cm_busy", 8'(busy), 8'h01);

        // Asynchronous reset during tank 2 commit, observed before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("ar_mode", 8'(mode), 8'h00);
        check("ar_wren", 8'(wren), 8'h00);
        check("ar_load", 8'(load_out), 8'h00);
        check("ar_busy", 8'(busy), 8'h00);
        check("ar_data", data, 8'h00);
        check("ar_done", 8'(frame_done), 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;
        step();
        check("post_rst_busy", 8'(busy), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
